// File: rtl/pend_dispatch_pkg.sv
// rtl/pend_dispatch_pkg.sv - shared widths, vector type and FSM state for pend_dispatch
package pend_dispatch_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] req_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/pend_prio_enc.sv
// rtl/pend_prio_enc.sv - combinational highest-set-bit encoder
//
// Ports:
//   req_i  in   N  request vector, bit N-1 has highest priority
//   idx_o  out  W  index of the highest set bit (0 when none set)
//   any_o  out  1  at least one bit of req_i is set
module pend_prio_enc
    import pend_dispatch_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = IDX_W
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/pend_dispatch.sv
// rtl/pend_dispatch.sv - sticky request collector with highest-index valid/ready dispatch
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   req_i        in   N_REQ  request pulses, ORed into the pending vector
//   out_ready_i  in   1      consumer accepts the offered index
//   out_valid_o  out  1      offered index is valid (registered)
//   out_idx_o    out  IDX_W  offered index, held until accepted (registered)
//   pend_o       out  N_REQ  pending request vector (registered)
//   ovf_o        out  1      sticky duplicate-request flag (PEND_OVF_EN only)
//   ovf_clr_i    in   1      clears ovf_o (PEND_OVF_EN only)
//
// Build option: define PEND_OVF_EN to add the overflow flag and its clear input.
module pend_dispatch
    import pend_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o,
`ifdef PEND_OVF_EN
    output logic             ovf_o,
    input  logic             ovf_clr_i,
`endif
    output logic [N_REQ-1:0] pend_o
);

    state_t           state_q, state_d;
    req_vec_t         pend_q, pend_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    req_vec_t         clr_mask;
    logic             handshake;
    logic [IDX_W-1:0] enc_idx;
    logic             pend_any;

    pend_prio_enc #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_enc (
        .req_i (pend_q),
        .idx_o (enc_idx),
        .any_o (pend_any)
    );

    assign handshake = out_valid_q & out_ready_i;
    assign clr_mask  = handshake ? (req_vec_t'(1) << out_idx_q) : '0;

    // Request OR applied after the clear so a same-cycle re-request survives.
    assign pend_d = (pend_q & ~clr_mask) | req_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_any)    state_d = OFFER;
            OFFER:   if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Index is latched only on the IDLE->OFFER step, keeping it stable
    // through the whole offer even if a higher request lands meanwhile.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            IDLE: begin
                if (pend_any) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = enc_idx;
                end
            end
            OFFER: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                end
            end
            default: out_valid_d = 1'b0;
        endcase
    end

`ifdef PEND_OVF_EN
    logic ovf_q, ovf_d;

    // Duplicate request on a bit that stays pending; set wins over clear.
    always_comb begin
        ovf_d = ovf_q & ~ovf_clr_i;
        if (|(req_i & pend_q & ~clr_mask)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign pend_o      = pend_q;

endmodule

// File: tb/tb_pend_dispatch.sv
// tb/tb_pend_dispatch.sv - scoreboard testbench for pend_dispatch
module tb_pend_dispatch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_i = 8'h00;
    logic       out_ready_i = 1'b0;
    logic       out_valid_o;
    logic [2:0] out_idx_o;
    logic [7:0] pend_o;
`ifdef PEND_OVF_EN
    logic       ovf_o;
    logic       ovf_clr_i = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    pend_dispatch dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_idx_o   (out_idx_o),
`ifdef PEND_OVF_EN
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i),
`endif
        .pend_o      (pend_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next posedge when valid & ready
    // are both high mid-cycle and reset is low.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got idx %0d expected none", out_idx_o);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_idx_o) != e) begin
                    failures++;
                    $display("FAIL sb_idx: got %0d expected %0d", out_idx_o, e);
                end
            end
        end
    end

    // Bounded drain: wait for idle with nothing pending.
    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready_i = 1'b1;
        while ((out_valid_o || pend_o != 8'h00) && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, int'(n < 50), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requests asserted: reset must win.
        rst = 1'b1; req_i = 8'hFF;
        tick(); tick();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_pend", pend_o, 0);
        chk("rst_idx", out_idx_o, 0);
`ifdef PEND_OVF_EN
        chk("rst_ovf", ovf_o, 0);
`endif
        rst = 1'b0; req_i = 8'h00;
        tick();
        chk("idle_valid", out_valid_o, 0);

        // Single request, latency N+2, bit cleared after accept.
        out_ready_i = 1'b1;
        exp_q.push_back(2);
        req_i = 8'h04;
        tick();
        req_i = 8'h00;
        chk("single_pend_n1", pend_o, 8'h04);
        chk("single_valid_n1", out_valid_o, 0);
        tick();
        chk("single_valid_n2", out_valid_o, 1);
        chk("single_idx", out_idx_o, 2);
        tick();
        chk("single_pend_after", pend_o, 0);
        chk("single_valid_after", out_valid_o, 0);

        // Ordering 8'hA5 -> 7,5,2,0 with one bubble between grants.
        exp_q.push_back(7); exp_q.push_back(5);
        exp_q.push_back(2); exp_q.push_back(0);
        req_i = 8'hA5;
        tick();
        req_i = 8'h00;
        chk("ord_pend", pend_o, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ord_valid_hi", out_valid_o, 1);
            tick();
            chk("ord_bubble", out_valid_o, 0);
        end
        chk("ord_pend_end", pend_o, 0);
        tick();
        chk("ord_idle", out_valid_o, 0);

        // Hold: idx 3 stays while ready low, even after higher request.
        out_ready_i = 1'b0;
        exp_q.push_back(3); exp_q.push_back(7);
        req_i = 8'h08;
        tick();
        req_i = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_idx", out_idx_o, 3);
            tick();
        end
        req_i = 8'h80;
        tick();
        req_i = 8'h00;
        chk("hold_idx_after_hi", out_idx_o, 3);
        chk("hold_valid", out_valid_o, 1);
        chk("hold_pend", pend_o, 8'h88);
        out_ready_i = 1'b1;
        tick();
        chk("hold_pend_acc", pend_o, 8'h80);
        chk("hold_bubble", out_valid_o, 0);
        tick();
        chk("hold_next_idx", out_idx_o, 7);
        chk("hold_next_valid", out_valid_o, 1);
        tick();
        chk("hold_pend_end", pend_o, 0);

        // Set beats clear on the accepted bit.
        out_ready_i = 1'b0;
        req_i = 8'h08;
        tick();
        req_i = 8'h00;
        tick();
        chk("svc_offer", out_idx_o, 3);
        exp_q.push_back(3); exp_q.push_back(3);
        out_ready_i = 1'b1;
        req_i = 8'h08;
        tick();
        req_i = 8'h00;
        chk("svc_pend_kept", pend_o, 8'h08);
        chk("svc_bubble", out_valid_o, 0);
        tick();
        chk("svc_reoffer_valid", out_valid_o, 1);
        chk("svc_reoffer_idx", out_idx_o, 3);
        tick();
        chk("svc_pend_end", pend_o, 0);

`ifdef PEND_OVF_EN
        // Duplicate request on a held bit raises the sticky flag.
        out_ready_i = 1'b0;
        req_i = 8'h10;
        tick();
        chk("ovf_first", ovf_o, 0);
        tick();
        req_i = 8'h00;
        chk("ovf_set", ovf_o, 1);
        tick();
        chk("ovf_sticky", ovf_o, 1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("ovf_clr", ovf_o, 0);
        exp_q.push_back(4);
        drain("ovf");
`endif

        // Reset during an offer drops it without a handshake.
        out_ready_i = 1'b0;
        req_i = 8'h42;
        tick();
        req_i = 8'h00;
        tick();
        chk("rmid_offer", out_valid_o, 1);
        rst = 1'b1;
        out_ready_i = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_valid", out_valid_o, 0);
        chk("rmid_pend", pend_o, 0);
        tick(); tick();
        chk("rmid_quiet", out_valid_o, 0);

        drain("final");
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
